// File: rtl/mem_stage_if.sv
// Handshake and bus bundle for the MIPS M stage: E/M input record, data-bus
// request/response, and the registered M/W record presented to WriteBack.
interface mem_stage_if #(
   parameter int OP_W  = 6,
   parameter int REG_W = 5
);
   // E/M record from Execute
   logic              m_valid;
   logic              m_ready;
   logic [OP_W-1:0]   m_opcode;
   logic [OP_W-1:0]   m_funct;
   logic [31:0]       m_valE;
   logic [31:0]       m_valB;
   logic [REG_W-1:0]  m_dstE;
   logic [REG_W-1:0]  m_dstM;

   // Data-bus request and response
   logic              dreq_valid;
   logic [31:0]       dreq_addr;
   logic [2:0]        dreq_size;
   logic [3:0]        dreq_strobe;
   logic [31:0]       dreq_data;
   logic              dresp_addr_ok;
   logic              dresp_data_ok;
   logic [31:0]       dresp_data;

   // M/W record to WriteBack
   logic              w_valid;
   logic [OP_W-1:0]   w_opcode;
   logic [OP_W-1:0]   w_funct;
   logic [31:0]       w_valE;
   logic [31:0]       w_valM;
   logic [REG_W-1:0]  w_dstE;
   logic [REG_W-1:0]  w_dstM;

   // The M stage itself
   modport slave (
      input  m_valid, m_opcode, m_funct, m_valE, m_valB, m_dstE, m_dstM,
      output m_ready,
      output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      input  dresp_addr_ok, dresp_data_ok, dresp_data,
      output w_valid, w_opcode, w_funct, w_valE, w_valM, w_dstE, w_dstM
   );

   // The surrounding pipeline and memory system
   modport master (
      output m_valid, m_opcode, m_funct, m_valE, m_valB, m_dstE, m_dstM,
      input  m_ready,
      input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      output dresp_addr_ok, dresp_data_ok, dresp_data,
      input  w_valid, w_opcode, w_funct, w_valE, w_valM, w_dstE, w_dstM
   );
endinterface

// File: rtl/mem_stage.sv
// MIPS pipeline M stage: issues data-bus loads/stores, stalls upstream across bus
// latency, and presents a registered M/W record. Sub-word accesses: MEM_SUBWORD_EN.
module mem_stage #(
   parameter int OP_W  = 6,
   parameter int REG_W = 5
) (
   input  logic        clk,
   input  logic        reset,
   mem_stage_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   localparam logic [OP_W-1:0] OP_LW  = OP_W'(6'h23);
   localparam logic [OP_W-1:0] OP_SW  = OP_W'(6'h2B);
`ifdef MEM_SUBWORD_EN
   localparam logic [OP_W-1:0] OP_LB  = OP_W'(6'h20);
   localparam logic [OP_W-1:0] OP_LH  = OP_W'(6'h21);
   localparam logic [OP_W-1:0] OP_LBU = OP_W'(6'h24);
   localparam logic [OP_W-1:0] OP_LHU = OP_W'(6'h25);
   localparam logic [OP_W-1:0] OP_SB  = OP_W'(6'h28);
   localparam logic [OP_W-1:0] OP_SH  = OP_W'(6'h29);
`endif

   function automatic logic is_load(input logic [OP_W-1:0] op);
`ifdef MEM_SUBWORD_EN
      return op inside {OP_LW, OP_LB, OP_LH, OP_LBU, OP_LHU};
`else
      return op == OP_LW;
`endif
   endfunction

   function automatic logic is_store(input logic [OP_W-1:0] op);
`ifdef MEM_SUBWORD_EN
      return op inside {OP_SW, OP_SB, OP_SH};
`else
      return op == OP_SW;
`endif
   endfunction

   logic [1:0]        state;
   logic [OP_W-1:0]   r_opcode;
   logic [OP_W-1:0]   r_funct;
   logic [31:0]       r_valE;
   logic [31:0]       r_valB;
   logic [REG_W-1:0]  r_dstE;
   logic [REG_W-1:0]  r_dstM;

   logic              w_valid_q;
   logic [OP_W-1:0]   w_opcode_q;
   logic [OP_W-1:0]   w_funct_q;
   logic [31:0]       w_valE_q;
   logic [31:0]       w_valM_q;
   logic [REG_W-1:0]  w_dstE_q;
   logic [REG_W-1:0]  w_dstM_q;

   logic        in_idle;
   logic        in_mem;
   logic        accept_alu;
   logic        accept_mem;
   logic        retire;
   logic [2:0]  size_c;
   logic [3:0]  strobe_c;
   logic [31:0] wdata_c;
   logic [31:0] load_c;

   assign in_idle    = (state == S_IDLE);
   assign in_mem     = is_load(bus.m_opcode) || is_store(bus.m_opcode);
   assign accept_alu = in_idle && bus.m_valid && !in_mem;
   assign accept_mem = in_idle && bus.m_valid && in_mem;
   // data_ok only counts once the request has been accepted (same cycle or later)
   assign retire     = ((state == S_REQ)  && bus.dresp_addr_ok && bus.dresp_data_ok) ||
                       ((state == S_WAIT) && bus.dresp_data_ok);

   // Request attributes derive from the latched record, so they hold steady in REQ.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      size_c   = 3'd2;
      strobe_c = 4'b0000;
      wdata_c  = '0;
      case (r_opcode)
         OP_SW: begin
            strobe_c = 4'b1111;
            wdata_c  = r_valB;
         end
`ifdef MEM_SUBWORD_EN
         OP_LB, OP_LBU: size_c = 3'd0;
         OP_LH, OP_LHU: size_c = 3'd1;
         OP_SB: begin
            size_c   = 3'd0;
            strobe_c = 4'b0001 << r_valE[1:0];
            wdata_c  = {4{r_valB[7:0]}};
         end
         OP_SH: begin
            size_c   = 3'd1;
            strobe_c = r_valE[1] ? 4'b1100 : 4'b0011;
            wdata_c  = {2{r_valB[15:0]}};
         end
`endif
         default: ;
      endcase
   end

`ifdef MEM_SUBWORD_EN
   logic [31:0] lane_word;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Little-endian lane pick: byte lane from addr[1:0], half lane from addr[1]
   assign lane_word = bus.dresp_data >> {r_valE[1:0], 3'b000};
   assign lane_b    = lane_word[7:0];
   assign lane_h    = r_valE[1] ? bus.dresp_data[31:16] : bus.dresp_data[15:0];

   always_comb begin
      load_c = bus.dresp_data;
      case (r_opcode)
         OP_LB:   load_c = {{24{lane_b[7]}}, lane_b};
         OP_LBU:  load_c = {24'd0, lane_b};
         OP_LH:   load_c = {{16{lane_h[15]}}, lane_h};
         OP_LHU:  load_c = {16'd0, lane_h};
         default: ;
      endcase
   end
`else
   assign load_c = bus.dresp_data;
`endif

   // Control FSM and the latched E/M record of the in-flight memory access
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: only control state and the small record are reset; an async reset
      // abandons the access at once, so the bus request drops without a clock edge.
      if (reset) begin
         state    <= S_IDLE;
         r_opcode <= '0;
         r_funct  <= '0;
         r_valE   <= '0;
         r_valB   <= '0;
         r_dstE   <= '0;
         r_dstM   <= '0;
      end else begin
         // NOTE: non-blocking assignments for all state so every block sees pre-edge values.
         case (state)
            S_IDLE: begin
               if (accept_mem) begin
                  r_opcode <= bus.m_opcode;
                  r_funct  <= bus.m_funct;
                  r_valE   <= bus.m_valE;
                  r_valB   <= bus.m_valB;
                  r_dstE   <= bus.m_dstE;
                  r_dstM   <= bus.m_dstM;
                  state    <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus.dresp_addr_ok)
                  state <= bus.dresp_data_ok ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
               if (bus.dresp_data_ok)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // M/W record: fields hold between retirements, w_valid pulses once per instruction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_valid_q  <= 1'b0;
         w_opcode_q <= '0;
         w_funct_q  <= '0;
         w_valE_q   <= '0;
         w_valM_q   <= '0;
         w_dstE_q   <= '0;
         w_dstM_q   <= '0;
      end else begin
         w_valid_q <= 1'b0;
         if (accept_alu) begin
            w_valid_q  <= 1'b1;
            w_opcode_q <= bus.m_opcode;
            w_funct_q  <= bus.m_funct;
            w_valE_q   <= bus.m_valE;
            w_valM_q   <= '0;
            w_dstE_q   <= bus.m_dstE;
            w_dstM_q   <= bus.m_dstM;
         end else if (retire) begin
            w_valid_q  <= 1'b1;
            w_opcode_q <= r_opcode;
            w_funct_q  <= r_funct;
            w_valE_q   <= r_valE;
            w_valM_q   <= is_store(r_opcode) ? 32'd0 : load_c;
            w_dstE_q   <= r_dstE;
            w_dstM_q   <= r_dstM;
         end
      end
   end

   assign bus.m_ready     = in_idle;
   assign bus.dreq_valid  = (state == S_REQ);
   assign bus.dreq_addr   = r_valE;
   assign bus.dreq_size   = size_c;
   assign bus.dreq_strobe = is_store(r_opcode) ? strobe_c : 4'b0000;
   assign bus.dreq_data   = wdata_c;

   assign bus.w_valid  = w_valid_q;
   assign bus.w_opcode = w_opcode_q;
   assign bus.w_funct  = w_funct_q;
   assign bus.w_valE   = w_valE_q;
   assign bus.w_valM   = w_valM_q;
   assign bus.w_dstE   = w_dstE_q;
   assign bus.w_dstM   = w_dstM_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level model of the M stage plus
// directed cases; sub-word cases run when MEM_SUBWORD_EN is defined.
module tb_mem_stage;
   localparam int OP_W  = 6;
   localparam int REG_W = 5;
`ifdef MEM_SUBWORD_EN
   localparam bit SUBWORD = 1'b1;
`else
   localparam bit SUBWORD = 1'b0;
`endif

   typedef struct packed {
      logic [5:0]  op;
      logic [5:0]  funct;
      logic [31:0] valE;
      logic [31:0] valB;
      logic [4:0]  dstE;
      logic [4:0]  dstM;
   } instr_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_stage_if #(.OP_W(OP_W), .REG_W(REG_W)) bus ();
   mem_stage #(.OP_W(OP_W), .REG_W(REG_W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // 0 = non-memory, 1 = load, 2 = store
   function automatic int kind(input logic [5:0] op);
      case (op)
         6'h23: return 1;
         6'h2B: return 2;
         6'h20, 6'h21, 6'h24, 6'h25: return SUBWORD ? 1 : 0;
         6'h28, 6'h29: return SUBWORD ? 2 : 0;
         default: return 0;
      endcase
   endfunction

   function automatic int nbytes(input logic [5:0] op);
      case (op)
         6'h20, 6'h24, 6'h28: return 1;
         6'h21, 6'h25, 6'h29: return 2;
         default: return 4;
      endcase
   endfunction

   function automatic int lane0(input logic [5:0] op, input logic [31:0] addr);
      int nb = nbytes(op);
      return (int'(addr % 4) / nb) * nb;
   endfunction

   function automatic logic [2:0] model_size(input logic [5:0] op);
      int nb = nbytes(op);
      return (nb == 1) ? 3'd0 : (nb == 2) ? 3'd1 : 3'd2;
   endfunction

   function automatic logic [3:0] model_strobe(input logic [5:0] op, input logic [31:0] addr);
      int m;
      if (kind(op) != 2) return 4'b0000;
      m = ((1 << nbytes(op)) - 1) << lane0(op, addr);
      return m[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] valB);
      longint unsigned mask, v, d;
      int nb = nbytes(op);
      mask = (64'd1 << (8 * nb)) - 1;
      v = valB & mask;
      d = 0;
      for (int k = 0; k < 4; k += nb) d |= v << (8 * k);
      return d[31:0];
   endfunction

   function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr,
                                              input logic [31:0] rd);
      longint unsigned mask, f;
      int nb = nbytes(op);
      mask = (64'd1 << (8 * nb)) - 1;
      f = (64'(rd) >> (8 * lane0(op, addr))) & mask;
      if ((op == 6'h20 || op == 6'h21) && f[8*nb-1]) f |= ~mask;
      return f[31:0];
   endfunction

   // ---------------- per-cycle expectations ----------------
   bit          chk_en = 1'b0;
   logic        exp_m_ready, exp_dreq_valid;
   logic [31:0] exp_addr, exp_data;
   logic [2:0]  exp_size;
   logic [3:0]  exp_strobe;
   bit          exp_data_chk;
   logic        exp_w_valid;
   instr_t      exp_w;
   logic [31:0] exp_w_valM;
   bit          exp_valm_known;

   bit          pend_valid = 1'b0;
   instr_t      pend;
   logic [31:0] pend_valM;
   bit          pend_valm_known;

   logic [3:0]  seen_strobe;
   logic [31:0] seen_data;

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_ready", bus.m_ready, exp_m_ready);
         check("dreq_valid", bus.dreq_valid, exp_dreq_valid);
         if (exp_dreq_valid) begin
            check("dreq_addr", bus.dreq_addr, exp_addr);
            check("dreq_size", bus.dreq_size, exp_size);
            check("dreq_strobe", bus.dreq_strobe, exp_strobe);
            if (exp_data_chk) check("dreq_data", bus.dreq_data, exp_data);
         end
         check("w_valid", bus.w_valid, exp_w_valid);
         check("w_opcode", bus.w_opcode, exp_w.op);
         check("w_funct", bus.w_funct, exp_w.funct);
         check("w_valE", bus.w_valE, exp_w.valE);
         check("w_dstE", bus.w_dstE, exp_w.dstE);
         check("w_dstM", bus.w_dstM, exp_w.dstM);
         if (exp_valm_known) check("w_valM", bus.w_valM, exp_w_valM);
      end
   end

   // Advance one clock; a record scheduled to retire at this edge becomes visible.
   task automatic cycle();
      @(posedge clk);
      #1;
      exp_w_valid = pend_valid;
      if (pend_valid) begin
         exp_w          = pend;
         exp_valm_known = pend_valm_known;
         exp_w_valM     = pend_valM;
      end
      pend_valid = 1'b0;
   endtask

   task automatic garbage_upstream();
      bus.m_valid  = 1'($urandom_range(0, 1));
      bus.m_opcode = 6'($urandom);
      bus.m_funct  = 6'($urandom);
      bus.m_valE   = $urandom;
      bus.m_valB   = $urandom;
      bus.m_dstE   = 5'($urandom);
      bus.m_dstM   = 5'($urandom);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         bus.m_valid       = 1'b0;
         bus.dresp_addr_ok = 1'b0;
         bus.dresp_data_ok = 1'($urandom_range(0, 1));
         bus.dresp_data    = $urandom;
         exp_m_ready       = 1'b1;
         exp_dreq_valid    = 1'b0;
         cycle();
      end
   endtask

   // Present one instruction in an IDLE cycle and play the bus side with the given
   // addr_ok delay (REQ cycles before accept) and data_ok delay (cycles after accept).
   task automatic run_instr(input instr_t in, input int a_dly, input int d_dly,
                            input logic [31:0] rd);
      int k = kind(in.op);
      bus.m_valid       = 1'b1;
      bus.m_opcode      = in.op;
      bus.m_funct       = in.funct;
      bus.m_valE        = in.valE;
      bus.m_valB        = in.valB;
      bus.m_dstE        = in.dstE;
      bus.m_dstM        = in.dstM;
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'($urandom_range(0, 1));
      bus.dresp_data    = $urandom;
      exp_m_ready       = 1'b1;
      exp_dreq_valid    = 1'b0;
      if (k == 0) begin
         pend = in; pend_valm_known = 1'b0; pend_valM = '0; pend_valid = 1'b1;
         cycle();
         return;
      end
      cycle();
      seen_strobe    = bus.dreq_strobe;
      seen_data      = bus.dreq_data;
      exp_m_ready    = 1'b0;
      exp_dreq_valid = 1'b1;
      exp_addr       = in.valE;
      exp_size       = model_size(in.op);
      exp_strobe     = model_strobe(in.op, in.valE);
      exp_data       = model_wdata(in.op, in.valB);
      exp_data_chk   = (k == 2);
      for (int i = 0; i < a_dly; i++) begin
         garbage_upstream();
         bus.dresp_addr_ok = 1'b0;
         bus.dresp_data_ok = 1'($urandom_range(0, 1));
         bus.dresp_data    = $urandom;
         cycle();
      end
      garbage_upstream();
      pend            = in;
      pend_valm_known = 1'b1;
      pend_valM       = (k == 2) ? 32'd0 : model_load(in.op, in.valE, rd);
      bus.dresp_addr_ok = 1'b1;
      if (d_dly == 0) begin
         bus.dresp_data_ok = 1'b1;
         bus.dresp_data    = rd;
         pend_valid        = 1'b1;
         cycle();
      end else begin
         bus.dresp_data_ok = 1'b0;
         cycle();
         exp_dreq_valid    = 1'b0;
         bus.dresp_addr_ok = 1'b0;
         for (int i = 0; i < d_dly - 1; i++) begin
            garbage_upstream();
            bus.dresp_data_ok = 1'b0;
            cycle();
         end
         garbage_upstream();
         bus.dresp_data_ok = 1'b1;
         bus.dresp_data    = rd;
         pend_valid        = 1'b1;
         cycle();
      end
      bus.m_valid       = 1'b0;
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'b0;
      exp_m_ready       = 1'b1;
      exp_dreq_valid    = 1'b0;
   endtask

   function automatic instr_t mk(input logic [5:0] op, input logic [31:0] valE,
                                 input logic [31:0] valB, input logic [4:0] dstE,
                                 input logic [4:0] dstM);
      instr_t r;
      r.op = op; r.funct = 6'h21; r.valE = valE; r.valB = valB; r.dstE = dstE; r.dstM = dstM;
      return r;
   endfunction

   logic [5:0] op_pool [13];
   initial op_pool = '{6'h00, 6'h09, 6'h0D, 6'h0F, 6'h3F, 6'h23, 6'h2B,
                       6'h20, 6'h21, 6'h24, 6'h25, 6'h28, 6'h29};

   initial begin
      instr_t in;
      reset = 1'b1;
      bus.m_valid = 1'b0; bus.m_opcode = '0; bus.m_funct = '0; bus.m_valE = '0;
      bus.m_valB = '0; bus.m_dstE = '0; bus.m_dstM = '0;
      bus.dresp_addr_ok = 1'b0; bus.dresp_data_ok = 1'b0; bus.dresp_data = '0;
      exp_w = '0; exp_w_valM = '0; exp_valm_known = 1'b1; exp_w_valid = 1'b0;
      exp_m_ready = 1'b1; exp_dreq_valid = 1'b0; exp_data_chk = 1'b0;
      exp_addr = '0; exp_size = '0; exp_strobe = '0; exp_data = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_w_valid", bus.w_valid, 0);
      check("rst_w_valE", bus.w_valE, 0);
      check("rst_w_valM", bus.w_valM, 0);
      check("rst_dreq_valid", bus.dreq_valid, 0);
      check("rst_m_ready", bus.m_ready, 1);
      reset  = 1'b0;
      chk_en = 1'b1;
      idle_cycles(1);

      // ADDIU passthrough, then back-to-back ADDIUs
      run_instr(mk(6'h09, 32'h1234, 32'h0, 5'd3, 5'd0), 0, 0, '0);
      check("addiu_w_valid", bus.w_valid, 1);
      check("addiu_w_valE", bus.w_valE, 32'h1234);
      check("addiu_w_dstE", bus.w_dstE, 3);
      for (int i = 0; i < 4; i++)
         run_instr(mk(6'h09, 32'h100 + i, 32'h0, 5'(i + 4), 5'd0), 0, 0, '0);
      idle_cycles(1);

      // LW, accepted and answered in the first REQ cycle
      run_instr(mk(6'h23, 32'h100, 32'h0, 5'd0, 5'd7), 0, 0, 32'hDEADBEEF);
      check("lw_w_valid", bus.w_valid, 1);
      check("lw_w_valM", bus.w_valM, 32'hDEADBEEF);
      idle_cycles(1);

      // SW with a 3-cycle addr_ok delay and data_ok 2 cycles after accept
      run_instr(mk(6'h2B, 32'h104, 32'hCAFEF00D, 5'd0, 5'd0), 3, 2, 32'h5555AAAA);
      check("sw_strobe", seen_strobe, 4'b1111);
      check("sw_data", seen_data, 32'hCAFEF00D);
      check("sw_w_valM", bus.w_valM, 0);
      idle_cycles(1);

`ifdef MEM_SUBWORD_EN
      run_instr(mk(6'h20, 32'h103, 32'h0, 5'd0, 5'd8), 1, 1, 32'h80FF0000);
      check("lb_w_valM", bus.w_valM, 32'hFFFFFF80);
      run_instr(mk(6'h24, 32'h103, 32'h0, 5'd0, 5'd9), 0, 0, 32'h80FF0000);
      check("lbu_w_valM", bus.w_valM, 32'h00000080);
      run_instr(mk(6'h29, 32'h102, 32'hABCD, 5'd0, 5'd0), 0, 1, 32'h0);
      check("sh_strobe", seen_strobe, 4'b1100);
      check("sh_data", seen_data, 32'hABCDABCD);
      idle_cycles(1);
`endif

      // Reset while waiting for data: everything drops without a clock edge
      bus.m_valid = 1'b1; bus.m_opcode = 6'h23; bus.m_valE = 32'h200;
      bus.m_valB = '0; bus.m_dstE = '0; bus.m_dstM = 5'd2; bus.m_funct = '0;
      bus.dresp_addr_ok = 1'b0; bus.dresp_data_ok = 1'b0;
      exp_m_ready = 1'b1; exp_dreq_valid = 1'b0;
      cycle();
      bus.m_valid = 1'b0;
      exp_m_ready = 1'b0; exp_dreq_valid = 1'b1; exp_addr = 32'h200;
      exp_size = 3'd2; exp_strobe = 4'b0000; exp_data_chk = 1'b0;
      bus.dresp_addr_ok = 1'b1;
      cycle();
      bus.dresp_addr_ok = 1'b0;
      exp_dreq_valid = 1'b0;
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      check("wait_dreq_valid", bus.dreq_valid, 0);
      reset = 1'b1;
      #1;
      check("arst_dreq_valid", bus.dreq_valid, 0);
      check("arst_w_valid", bus.w_valid, 0);
      check("arst_w_valE", bus.w_valE, 0);
      check("arst_m_ready", bus.m_ready, 1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_w = '0; exp_w_valM = '0; exp_valm_known = 1'b1; exp_w_valid = 1'b0;
      pend_valid = 1'b0;
      exp_m_ready = 1'b1; exp_dreq_valid = 1'b0;
      bus.dresp_data_ok = 1'b1; bus.dresp_data = 32'h12345678;
      chk_en = 1'b1;
      cycle();
      check("post_rst_w_valid", bus.w_valid, 0);
      bus.dresp_data_ok = 1'b0;
      idle_cycles(1);

      // Randomized instruction stream with random bus latencies
      for (int n = 0; n < 400; n++) begin
         in.op    = op_pool[$urandom_range(0, 12)];
         in.funct = 6'($urandom);
         in.valE  = $urandom;
         in.valB  = $urandom;
         in.dstE  = 5'($urandom);
         in.dstM  = 5'($urandom);
         run_instr(in, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
         if ($urandom_range(0, 4) == 0) idle_cycles($urandom_range(1, 2));
      end
      idle_cycles(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline M stage of the 5-stage MIPS core; sits between Execute and WriteBack.
- Accepts one instruction per handshake from the E/M register, issues data-bus requests for loads/stores, and waits out bus latency while stalling upstream.
- Presents a registered M/W record (opcode, funct, valE, valM, dstE, dstM) to WriteBack; valM carries already-captured load data.

Parameters:
- OP_W, 6, opcode/funct field width
- REG_W, 5, register index width

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- m_valid  in  1  E/M record valid
- m_ready  out  1  stage accepts record this cycle
- m_opcode  in  OP_W  instruction opcode
- m_funct  in  OP_W  R-type funct
- m_valE  in  32  ALU result / effective address
- m_valB  in  32  store data (rt)
- m_dstE  in  REG_W  ALU destination
- m_dstM  in  REG_W  load destination
- dreq_valid  out  1  data-bus request valid
- dreq_addr  out  32  byte address
- dreq_size  out  3  0=byte, 1=half, 2=word
- dreq_strobe  out  4  byte write enables; 0 for loads
- dreq_data  out  32  write data, byte-lane aligned
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  response/data valid
- dresp_data  in  32  raw read word
- w_valid  out  1  M/W record valid (one-cycle pulse per instruction)
- w_opcode, w_funct  out  OP_W  passed through
- w_valE  out  32  passed through
- w_valM  out  32  load result after extract/extend
- w_dstE, w_dstM  out  REG_W  passed through

Behaviour:
- Reset (async, active-high): state=IDLE; w_valid=0; all w_* fields 0; dreq_valid=0. Reset mid-transaction abandons the access immediately; no w_valid is produced for it.
- FSM: IDLE, REQ, WAIT. m_ready=1 only in IDLE.
- IDLE, m_valid=1, non-memory opcode: record captured at the edge; w_valid=1 next cycle; state stays IDLE. Throughput: 1/cycle.
- IDLE, m_valid=1, load/store: fields latched; go REQ. w_valid=0 next cycle.
- REQ: dreq_valid=1; addr/size/strobe/data stable until dresp_addr_ok. addr_ok & data_ok same cycle -> retire at this edge, go IDLE. addr_ok alone -> WAIT, dreq_valid drops.
- WAIT: dreq_valid=0. On data_ok, retire and go IDLE.
- Retire: w_* loaded from the latched record; w_valM captured from dresp_data in the data_ok cycle. Stores retire with w_valM=0.
- Minimum load latency: accept edge -> REQ cycle -> w_valid the following cycle, i.e. 2 cycles. Every stall cycle adds one.
- w_valid is high exactly one cycle per retired instruction; w_* fields hold their value otherwise.
- data_ok seen in IDLE or before addr_ok: ignored.
- LW (0x23): size=2, strobe=0. SW (0x2B): size=2, strobe=4'b1111, data=valB.
- Address low bits are passed unmodified.
- Unknown opcodes are treated as non-memory.

Optional Feature:
- Macro: MEM_SUBWORD_EN.
- Defined:
  - LB 0x20 / LBU 0x24: size=0.
  - LH 0x21 / LHU 0x25: size=1.
  - SB 0x28: strobe=1<<addr[1:0]; data=valB[7:0] replicated to all 4 lanes.
  - SH 0x29: strobe=addr[1]?4'b1100:4'b0011; data=valB[15:0] replicated to both halves.
  - Load result: lane selected by addr[1:0]; sign-extended for LB/LH, zero-extended for LBU/LHU.
- Undefined: these opcodes are non-memory (1-cycle passthrough, no bus request).

Test Plan:
- Reset asserted while in WAIT -> dreq_valid=0 and w_valid=0 with no clock edge; the next data_ok is ignored.
- ADDIU with valE=0x1234, dstE=3 accepted -> next cycle w_valid=1, w_valE=0x1234, w_dstE=3. Back-to-back ADDIUs retire every cycle.
- LW at addr 0x100, addr_ok and data_ok both high in REQ, data 0xDEADBEEF -> w_valid 2 cycles after accept, w_valM=0xDEADBEEF, m_ready=0 during REQ.
- SW at 0x104, valB=0xCAFEF00D, addr_ok delayed 3 cycles, data_ok 2 cycles later -> dreq fields stable during REQ, strobe=4'b1111, dreq_valid low in WAIT, single w_valid pulse.
- MEM_SUBWORD_EN: LB at 0x103, data 0x80FF0000 -> w_valM=0xFFFFFF80. LBU at the same address -> 0x00000080. SH at 0x102, valB=0xABCD -> strobe=4'b1100, data=0xABCDABCD.
